mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/luna_mem_pkg.sv | 33 +++
 rtl/mem_arb_pick.sv | 58 +++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/luna_mem_pkg.sv
// Shared encodings for the A/D/M memory bank arbiter: bank ops, arbiter states,
// requester indices and the op-to-enable decode.
package luna_mem_pkg;

  typedef enum logic [1:0] {
    OP_WR_A = 2'b00,
    OP_WR_D = 2'b01,
    OP_WR_M = 2'b10,
    OP_RD_M = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RD_CAP = 2'd2
  } state_t;

  localparam int RQ_CPU = 0;
  localparam int RQ_DMA = 1;
  localparam int NUM_RQ = 2;
  localparam int DATA_W = 16;

  // Returns {m_en, d_en, a_en}; a read first loads its address into A.
  function automatic logic [2:0] op_enables(input op_t op);
    case (op)
      OP_WR_A: op_enables = 3'b001;
      OP_WR_D: op_enables = 3'b010;
      OP_WR_M: op_enables = 3'b100;
      default: op_enables = 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the bank arbiter: round robin between two requesters,
// ownership lock, and the idle timeout that drops a lock nobody is using.
module mem_arb_pick
  import luna_mem_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idle,
  input  logic [NUM_RQ-1:0]   valid,
  input  logic [NUM_RQ-1:0]   lock,
  output logic [NUM_RQ-1:0]   grant
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  logic            last;
  logic            owner;
  logic            locked;
  logic [CW-1:0]   idle_cnt;
  logic [NUM_RQ-1:0] elig;
  logic            winner;

  always_comb begin
    elig = valid;
    if (locked) begin
      elig        = '0;
      elig[owner] = valid[owner];
    end
    winner = (elig == 2'b11) ? ~last : elig[1];
    grant  = '0;
    if (idle && !rst && (elig != '0)) grant[winner] = 1'b1;
  end

  // The lock ages only while the arbiter sits idle and its owner stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= 1'b1;
      owner    <= 1'b0;
      locked   <= 1'b0;
      idle_cnt <= '0;
    end else if (grant != '0) begin
      last     <= winner;
      owner    <= winner;
      locked   <= lock[winner];
      idle_cnt <= '0;
    end else if (idle && locked && !valid[owner]) begin
      if (idle_cnt == CW'(LOCK_MAX - 1)) begin
        locked   <= 1'b0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the A/D/M memory bank: accepts one op at a time,
// drives the bank write enables and captures RD_M results back to the owner.
module mem_arbiter
  import luna_mem_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rq0_valid,
  input  logic [1:0]  rq0_op,
  input  logic [15:0] rq0_data,
  input  logic        rq0_lock,
  output logic        rq0_ready,
  output logic [15:0] rq0_rdata,
  output logic        rq0_rvalid,
  input  logic        rq1_valid,
  input  logic [1:0]  rq1_op,
  input  logic [15:0] rq1_data,
  input  logic        rq1_lock,
  output logic        rq1_ready,
  output logic [15:0] rq1_rdata,
  output logic        rq1_rvalid,
  output logic        mem_a_en,
  output logic        mem_d_en,
  output logic        mem_m_en,
  output logic [15:0] mem_data,
  input  logic [15:0] mem_m_rd,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is accepted on a rising edge where rqN_valid and
  // rqN_ready are both high; the requester holds its fields until then.

  state_t            state;
  op_t               op_q;
  logic              owner_q;
  logic [2:0]        en_q;
  logic [15:0]       data_q;
  logic [NUM_RQ-1:0] rvalid_q;
  logic [15:0]       rdata0_q;
  logic [15:0]       rdata1_q;

  logic [NUM_RQ-1:0] grant;
  logic              sel;
  op_t               sel_op;
  logic [15:0]       sel_data;

  mem_arb_pick #(.LOCK_MAX(LOCK_MAX)) u_pick (
    .clk   (clk),
    .rst   (rst),
    .idle  (state == ST_IDLE),
    .valid ({rq1_valid, rq0_valid}),
    .lock  ({rq1_lock, rq0_lock}),
    .grant (grant)
  );

  assign sel      = grant[RQ_DMA];
  assign sel_op   = op_t'(sel ? rq1_op : rq0_op);
  assign sel_data = sel ? rq1_data : rq0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_WR_A;
      owner_q  <= 1'b0;
      en_q     <= '0;
      data_q   <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      en_q     <= '0;
      data_q   <= '0;
      rvalid_q <= '0;
      case (state)
        ST_IDLE: begin
          if (grant != '0) begin
            owner_q <= sel;
            op_q    <= sel_op;
            en_q    <= op_enables(sel_op);
            data_q  <= sel_data;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: state <= (op_q == OP_RD_M) ? ST_RD_CAP : ST_IDLE;
        ST_RD_CAP: begin
          if (owner_q) rdata1_q <= mem_m_rd;
          else         rdata0_q <= mem_m_rd;
          rvalid_q[owner_q] <= 1'b1;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset also masks the bank-facing strobes in the same cycle, so an op
  // caught in EXEC never reaches the bank on the reset edge.
  assign {mem_m_en, mem_d_en, mem_a_en} = rst ? 3'b000 : en_q;
  assign mem_data   = rst ? 16'h0000 : data_q;
  assign rq0_rvalid = rvalid_q[RQ_CPU] & ~rst;
  assign rq1_rvalid = rvalid_q[RQ_DMA] & ~rst;
  assign rq0_rdata  = rdata0_q;
  assign rq1_rdata  = rdata1_q;
  assign rq0_ready  = grant[RQ_CPU];
  assign rq1_ready  = grant[RQ_DMA];
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant table, hand-written bank/lock/reset
// sequences, and randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import luna_mem_pkg::*;

  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq0_valid, rq0_lock, rq0_ready, rq0_rvalid;
  logic [1:0]  rq0_op;
  logic [15:0] rq0_data, rq0_rdata;
  logic        rq1_valid, rq1_lock, rq1_ready, rq1_rvalid;
  logic [1:0]  rq1_op;
  logic [15:0] rq1_data, rq1_rdata;
  logic        mem_a_en, mem_d_en, mem_m_en;
  logic [15:0] mem_data, mem_m_rd;
  logic [1:0]  dbg_state;

  mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq0_op(rq0_op), .rq0_data(rq0_data), .rq0_lock(rq0_lock),
    .rq0_ready(rq0_ready), .rq0_rdata(rq0_rdata), .rq0_rvalid(rq0_rvalid),
    .rq1_valid(rq1_valid), .rq1_op(rq1_op), .rq1_data(rq1_data), .rq1_lock(rq1_lock),
    .rq1_ready(rq1_ready), .rq1_rdata(rq1_rdata), .rq1_rvalid(rq1_rvalid),
    .mem_a_en(mem_a_en), .mem_d_en(mem_d_en), .mem_m_en(mem_m_en),
    .mem_data(mem_data), .mem_m_rd(mem_m_rd), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / bank ----------------
  always #5 clk = ~clk;

  logic [15:0] bank_a, bank_d;
  logic [15:0] bank_mem [0:255];
  logic        bank_clr;

  assign mem_m_rd = bank_mem[bank_a[7:0]];

  always @(posedge clk) begin
    if (bank_clr) begin
      bank_a <= '0;
      bank_d <= '0;
      for (int i = 0; i < 256; i++) bank_mem[i] <= '0;
    end else begin
      if (mem_a_en) bank_a <= mem_data;
      if (mem_d_en) bank_d <= mem_data;
      if (mem_m_en) bank_mem[bank_a[7:0]] <= mem_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int w = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    w++;
  endtask

  task automatic set_rq(input int r, input logic v, input logic [1:0] op,
                        input logic [15:0] d, input logic l);
    if (r == 0) begin
      rq0_valid = v; rq0_op = op; rq0_data = d; rq0_lock = l;
    end else begin
      rq1_valid = v; rq1_op = op; rq1_data = d; rq1_lock = l;
    end
  endtask

  task automatic reset_dut();
    set_rq(0, 1'b0, 2'd0, 16'h0, 1'b0);
    set_rq(1, 1'b0, 2'd0, 16'h0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- grant table ----------------
  typedef struct {
    logic        v0, v1;
    logic [1:0]  op0, op1;
    logic [15:0] d0, d1;
    logic        er0, er1;
    logic [2:0]  een;   // {m, d, a}
    logic [15:0] edata;
  } vec_t;

  vec_t vecs [6];

  // ---------------- random-model state ----------------
  logic [18:0] exp_q [$];   // {m_en, d_en, a_en, data}
  logic [17:0] rd_q  [$];   // {rvalid[1:0], rdata}
  logic [15:0] m_mem [0:255];
  logic [15:0] m_a;
  logic [15:0] m_rdata [2];
  logic        hold [2];
  logic [1:0]  h_op [2];
  logic [15:0] h_data [2];
  logic        h_lock [2];

  initial begin
    int grants [8];
    int n;
    int last, owner, miss, idle_from, en_due, rd_due;
    bit locked;
    logic [18:0] ev;
    logic [17:0] rv;

    rst = 1'b1;
    bank_clr = 1'b1;
    set_rq(0, 1'b0, 2'd0, 16'h0, 1'b0);
    set_rq(1, 1'b0, 2'd0, 16'h0, 1'b0);
    tick();
    tick();

    // Reset holds ready low even with both requesters valid.
    rq0_valid = 1'b1;
    rq1_valid = 1'b1;
    #1;
    check("rst_ready0", 32'(rq0_ready), 0);
    check("rst_ready1", 32'(rq1_ready), 0);
    tick();
    bank_clr = 1'b0;
    rst = 1'b0;
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_en", 32'({mem_m_en, mem_d_en, mem_a_en}), 0);
    check("rst_mem_data", 32'(mem_data), 0);
    check("rst_rvalid", 32'({rq1_rvalid, rq0_rvalid}), 0);
    check("rst_rdata0", 32'(rq0_rdata), 0);
    check("rst_rdata1", 32'(rq1_rdata), 0);

    // ---------- table: single grant decisions straight out of reset ----------
    vecs[0] = '{1'b1, 1'b0, OP_WR_A, OP_WR_A, 16'h0100, 16'h0000, 1'b1, 1'b0, 3'b001, 16'h0100};
    vecs[1] = '{1'b0, 1'b1, OP_WR_A, OP_WR_D, 16'h0000, 16'h2222, 1'b0, 1'b1, 3'b010, 16'h2222};
    vecs[2] = '{1'b1, 1'b1, OP_WR_M, OP_WR_A, 16'h3333, 16'h0044, 1'b1, 1'b0, 3'b100, 16'h3333};
    vecs[3] = '{1'b0, 1'b1, OP_RD_M, OP_RD_M, 16'h0009, 16'h0005, 1'b0, 1'b1, 3'b001, 16'h0005};
    vecs[4] = '{1'b0, 1'b0, OP_WR_D, OP_WR_D, 16'h1111, 16'h2222, 1'b0, 1'b0, 3'b000, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, OP_WR_D, OP_WR_D, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 3'b010, 16'hAAAA};
    for (int i = 0; i < 6; i++) begin
      reset_dut();
      set_rq(0, vecs[i].v0, vecs[i].op0, vecs[i].d0, 1'b0);
      set_rq(1, vecs[i].v1, vecs[i].op1, vecs[i].d1, 1'b0);
      #1;
      check($sformatf("vec%0d_ready", i), 32'({rq1_ready, rq0_ready}),
            32'({vecs[i].er1, vecs[i].er0}));
      tick();
      set_rq(0, 1'b0, 2'd0, 16'h0, 1'b0);
      set_rq(1, 1'b0, 2'd0, 16'h0, 1'b0);
      check($sformatf("vec%0d_en", i), 32'({mem_m_en, mem_d_en, mem_a_en}), 32'(vecs[i].een));
      check($sformatf("vec%0d_data", i), 32'(mem_data), 32'(vecs[i].edata));
      tick();
      tick();
      tick();
    end

    // ---------- WR_A 0x0010 then WR_M 0xBEEF from rq0 ----------
    reset_dut();
    set_rq(0, 1'b1, OP_WR_A, 16'h0010, 1'b0);
    #1;
    check("wra_ready", 32'(rq0_ready), 1);
    tick();
    check("wra_en", 32'({mem_m_en, mem_d_en, mem_a_en}), 32'(3'b001));
    check("wra_data", 32'(mem_data), 32'h0010);
    check("wra_state", 32'(dbg_state), 32'(ST_EXEC));
    check("wra_ready_exec", 32'(rq0_ready), 0);
    set_rq(0, 1'b1, OP_WR_M, 16'hBEEF, 1'b0);
    tick();
    check("wra_bank_a", 32'(bank_a), 32'h0010);
    check("wrm_ready", 32'(rq0_ready), 1);
    tick();
    check("wrm_en", 32'({mem_m_en, mem_d_en, mem_a_en}), 32'(3'b100));
    check("wrm_data", 32'(mem_data), 32'hBEEF);
    rq0_valid = 1'b0;
    tick();
    check("wrm_bank", 32'(bank_mem[16]), 32'hBEEF);
    check("wrm_en_off", 32'({mem_m_en, mem_d_en, mem_a_en}), 0);
    check("wrm_data_off", 32'(mem_data), 0);

    // ---------- rq1 RD_M 0x0010 ----------
    set_rq(1, 1'b1, OP_RD_M, 16'h0010, 1'b0);
    #1;
    check("rd_ready", 32'(rq1_ready), 1);
    tick();
    check("rd_a_en", 32'({mem_m_en, mem_d_en, mem_a_en}), 32'(3'b001));
    check("rd_addr", 32'(mem_data), 32'h0010);
    rq1_valid = 1'b0;
    tick();
    check("rd_cap_state", 32'(dbg_state), 32'(ST_RD_CAP));
    check("rd_rvalid_early", 32'({rq1_rvalid, rq0_rvalid}), 0);
    tick();
    check("rd_rvalid", 32'({rq1_rvalid, rq0_rvalid}), 32'(2'b10));
    check("rd_rdata", 32'(rq1_rdata), 32'hBEEF);
    check("rd_bank_a", 32'(bank_a), 32'h0010);
    check("rd_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    check("rd_rvalid_pulse", 32'({rq1_rvalid, rq0_rvalid}), 0);
    check("rd_rdata_hold", 32'(rq1_rdata), 32'hBEEF);

    // ---------- round robin with both always valid ----------
    reset_dut();
    set_rq(0, 1'b1, OP_WR_D, 16'h00A0, 1'b0);
    set_rq(1, 1'b1, OP_WR_D, 16'h00B1, 1'b0);
    #1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (rq0_ready || rq1_ready) begin
        check("rr_onehot", 32'(rq0_ready & rq1_ready), 0);
        grants[n] = int'(rq1_ready);
        n++;
      end
      tick();
    end
    check("rr_count", 32'(n), 4);
    for (int k = 0; k < n; k++) check($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(k % 2));

    // ---------- lock timeout: rq1 locks then goes quiet ----------
    reset_dut();
    set_rq(1, 1'b1, OP_WR_D, 16'h0777, 1'b1);
    #1;
    check("lock_ready1", 32'(rq1_ready), 1);
    tick();
    set_rq(1, 1'b0, OP_WR_D, 16'h0000, 1'b0);
    set_rq(0, 1'b1, OP_WR_D, 16'h0888, 1'b0);
    #1;
    check("lock_exec_ready0", 32'(rq0_ready), 0);
    tick();
    for (int i = 1; i <= LOCK_MAX; i++) begin
      check($sformatf("lock_idle%0d_ready0", i), 32'(rq0_ready), 0);
      tick();
    end
    check("lock_timeout_ready0", 32'(rq0_ready), 1);
    tick();
    rq0_valid = 1'b0;
    tick();

    // ---------- lock released by owner's next lock=0 op ----------
    reset_dut();
    set_rq(1, 1'b1, OP_WR_D, 16'h0101, 1'b1);
    tick();
    set_rq(1, 1'b1, OP_WR_D, 16'h0202, 1'b0);
    set_rq(0, 1'b1, OP_WR_D, 16'h0303, 1'b0);
    tick();
    check("relock_ready", 32'({rq1_ready, rq0_ready}), 32'(2'b10));
    tick();
    rq1_valid = 1'b0;
    tick();
    check("release_ready", 32'({rq1_ready, rq0_ready}), 32'(2'b01));
    tick();
    rq0_valid = 1'b0;
    tick();

    // ---------- reset during EXEC of WR_D 0x1234 ----------
    reset_dut();
    set_rq(0, 1'b1, OP_WR_D, 16'h5555, 1'b0);
    tick();
    rq0_valid = 1'b0;
    tick();
    check("abort_pre_d", 32'(bank_d), 32'h5555);
    set_rq(0, 1'b1, OP_WR_D, 16'h1234, 1'b0);
    tick();
    rq0_valid = 1'b0;
    check("abort_exec_den", 32'(mem_d_en), 1);
    rst = 1'b1;
    #1;
    check("abort_den_in_rst", 32'(mem_d_en), 0);
    check("abort_data_in_rst", 32'(mem_data), 0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_den_after", 32'(mem_d_en), 0);
    tick();
    check("abort_bank_d", 32'(bank_d), 32'h5555);
    check("abort_den_later", 32'({mem_m_en, mem_d_en, mem_a_en}), 0);

    // ---------- randomized traffic vs transaction model ----------
    bank_clr = 1'b1;
    reset_dut();
    bank_clr = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_a = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    for (int r = 0; r < 2; r++) begin
      hold[r] = 1'b0; h_op[r] = 2'd0; h_data[r] = '0; h_lock[r] = 1'b0;
    end
    last = 1; owner = 0; locked = 0; miss = 0;
    idle_from = w; en_due = -1; rd_due = -1;
    exp_q.delete();
    rd_q.delete();

    for (int c = 0; c < 1600; c++) begin
      logic [1:0] elig;
      int g;
      bit idle;
      if (c < 1580) begin
        for (int r = 0; r < 2; r++) begin
          if (!hold[r] && $urandom_range(0, 1) == 1) begin
            hold[r]   = 1'b1;
            h_op[r]   = 2'($urandom_range(0, 3));
            h_data[r] = (h_op[r] == OP_WR_A || h_op[r] == OP_RD_M) ?
                        16'($urandom_range(0, 15)) : 16'($urandom_range(0, 65535));
            h_lock[r] = ($urandom_range(0, 4) == 0);
          end
        end
      end
      set_rq(0, hold[0], h_op[0], h_data[0], h_lock[0]);
      set_rq(1, hold[1], h_op[1], h_data[1], h_lock[1]);
      #1;

      idle = (w >= idle_from);
      elig = {hold[1], hold[0]};
      if (locked) begin
        elig = 2'b00;
        elig[owner] = hold[owner];
      end
      g = -1;
      if (idle && elig != 2'b00) g = (elig == 2'b11) ? 1 - last : (elig[1] ? 1 : 0);
      check("rnd_ready", 32'({rq1_ready, rq0_ready}),
            (g < 0) ? 0 : 32'(1 << g));

      if (w == en_due && exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        check("rnd_en", 32'({mem_m_en, mem_d_en, mem_a_en, mem_data}), 32'(ev));
      end else begin
        check("rnd_en_quiet", 32'({mem_m_en, mem_d_en, mem_a_en, mem_data}), 0);
      end
      if (w == rd_due && rd_q.size() > 0) begin
        rv = rd_q.pop_front();
        check("rnd_rvalid", 32'({rq1_rvalid, rq0_rvalid}), 32'(rv[17:16]));
        if (rv[16]) m_rdata[0] = rv[15:0];
        if (rv[17]) m_rdata[1] = rv[15:0];
      end else begin
        check("rnd_rvalid_quiet", 32'({rq1_rvalid, rq0_rvalid}), 0);
      end
      check("rnd_rdata0", 32'(rq0_rdata), 32'(m_rdata[0]));
      check("rnd_rdata1", 32'(rq1_rdata), 32'(m_rdata[1]));

      if (g >= 0) begin
        logic [15:0] d;
        d = h_data[g];
        last = g; owner = g; locked = h_lock[g]; miss = 0;
        en_due = w + 1;
        idle_from = w + 2;
        case (h_op[g])
          OP_WR_A: begin m_a = d; exp_q.push_back({3'b001, d}); end
          OP_WR_D: exp_q.push_back({3'b010, d});
          OP_WR_M: begin m_mem[m_a[7:0]] = d; exp_q.push_back({3'b100, d}); end
          default: begin
            m_a = d;
            exp_q.push_back({3'b001, d});
            rd_q.push_back({(g == 1) ? 2'b10 : 2'b01, m_mem[d[7:0]]});
            rd_due = w + 3;
            idle_from = w + 3;
          end
        endcase
        hold[g] = 1'b0;
      end else if (idle && locked && !hold[owner]) begin
        miss++;
        if (miss == LOCK_MAX) begin
          locked = 0;
          miss = 0;
        end
      end
      tick();
    end
    check("rnd_exp_drained", 32'(exp_q.size()), 0);
    check("rnd_rd_drained", 32'(rd_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
